// File: rtl/uart_cfg_if.sv
// Signal bundle for uart_cfg: serial lines, transmit handshake, receive outputs and
// flow-control status. The block is the slave; the surrounding logic is the master.
interface uart_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx;
    logic                 tx;
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_cts;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 is_receiving;
    logic                 is_transmitting;
    logic                 busy;
    logic                 rts;
    logic                 cts;

    modport slave (
        input  rx, tx_valid, tx_data, tx_cts, busy, rts,
        output tx, tx_ready, rx_valid, rx_data, parity_err, frame_err,
               is_receiving, is_transmitting, cts
    );

    modport master (
        output rx, tx_valid, tx_data, tx_cts, busy, rts,
        input  tx, tx_ready, rx_valid, rx_data, parity_err, frame_err,
               is_receiving, is_transmitting, cts
    );
endinterface

// File: rtl/uart_cfg.sv
// Configurable UART: independent oversampled receiver and transmitter, optional parity,
// one or two stop bits, CTS-gated transmit and a combinational RTS/busy flow-control output.
module uart_cfg #(
    parameter int unsigned CLK_DIV   = 1302,
    parameter int unsigned OS        = 4,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_cfg_if.slave bus
);
    localparam int unsigned     DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned     OsW      = $clog2(OS);
    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [OsW-1:0]  OsLast   = OsW'(OS - 1);
    localparam logic [OsW-1:0]  OsHalf   = OsW'(OS / 2 - 1);
    localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxPar, RxStop, RxDone, RxErr, RxHold
    } rx_state_e;
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_e;

    logic                 rx_meta_q, rx_sync_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [DivW-1:0]      rx_div_q, rx_div_d;
    logic [OsW-1:0]       rx_os_q, rx_os_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_tick, rx_half, rx_bit_end, rx_par_bad;

    tx_state_e            tx_state_q, tx_state_d;
    logic [DivW-1:0]      tx_div_q, tx_div_d;
    logic [OsW-1:0]       tx_os_q, tx_os_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d, tx_q, tx_d, tx_en_q, tx_ready, tx_bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rx_tick    = (rx_div_q == DivLast);
    assign rx_half    = rx_tick && (rx_os_q == OsHalf);
    assign rx_bit_end = rx_tick && (rx_os_q == OsLast);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q;
        rx_os_d    = rx_os_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_par_d   = rx_par_q;
        if (rx_state_q != RxIdle) begin
            rx_div_d = rx_tick ? '0 : rx_div_q + 1'b1;
            if (rx_tick) rx_os_d = (rx_os_q == OsLast) ? '0 : rx_os_q + 1'b1;
        end
        unique case (rx_state_q)
            RxIdle: if (!rx_sync_q) begin
                rx_state_d = RxStart;
                rx_div_d   = '0;
                rx_os_d    = '0;
            end
            // Re-phase the tick count at mid start bit so later samples land mid-bit.
            RxStart: if (rx_half) begin
                rx_os_d    = '0;
                rx_cnt_d   = '0;
                rx_par_d   = 1'b0;
                rx_state_d = rx_sync_q ? RxIdle : RxData;
            end
            RxData: if (rx_bit_end) begin
                rx_sh_d  = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
                rx_par_d = rx_par_q ^ rx_sync_q;
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == DataLast) rx_state_d = (PARITY != 0) ? RxPar : RxStop;
            end
            RxPar: if (rx_bit_end) begin
                rx_par_d   = rx_par_q ^ rx_sync_q;
                rx_state_d = RxStop;
            end
            RxStop: if (rx_bit_end) begin
                if (rx_sync_q) begin
                    rx_state_d = RxDone;
                    rx_data_d  = rx_sh_q;
                end else begin
                    rx_state_d = RxErr;
                end
            end
            RxDone: rx_state_d = RxIdle;
            RxErr: begin
                rx_state_d = RxHold;
                rx_div_d   = '0;
                rx_os_d    = '0;
                rx_cnt_d   = '0;
            end
            RxHold: begin
                if (rx_bit_end && (rx_cnt_q < 4'd2)) rx_cnt_d = rx_cnt_q + 4'd1;
                if ((rx_cnt_q == 4'd2) && rx_sync_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // rx_par_q is the XOR of data and parity bits: 1 means an odd count of ones.
    always_comb begin
        rx_par_bad = 1'b0;
        if (PARITY == 1) rx_par_bad = ~rx_par_q;
        else if (PARITY == 2) rx_par_bad = rx_par_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RxIdle;
            rx_div_q   <= '0;
            rx_os_q    <= '0;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_os_q    <= rx_os_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_par_q   <= rx_par_d;
        end
    end

    assign tx_bit_end = (tx_div_q == DivLast) && (tx_os_q == OsLast);
    // tx_en_q keeps the transmitter closed until the first clock edge after reset.
    assign tx_ready   = (tx_state_q == TxIdle) && bus.tx_cts && tx_en_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_os_d    = tx_os_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        if (tx_state_q != TxIdle) begin
            tx_div_d = (tx_div_q == DivLast) ? '0 : tx_div_q + 1'b1;
            if (tx_div_q == DivLast) tx_os_d = (tx_os_q == OsLast) ? '0 : tx_os_q + 1'b1;
        end
        unique case (tx_state_q)
            TxIdle: if (bus.tx_valid && tx_ready) begin
                tx_state_d = TxStart;
                tx_d       = 1'b0;
                tx_sh_d    = bus.tx_data;
                tx_par_d   = (PARITY == 1) ? ~(^bus.tx_data) : ^bus.tx_data;
                tx_div_d   = '0;
                tx_os_d    = '0;
            end
            TxStart: if (tx_bit_end) begin
                tx_state_d = TxData;
                tx_d       = tx_sh_q[0];
                tx_cnt_d   = '0;
            end
            TxData: if (tx_bit_end) begin
                if (tx_cnt_q == DataLast) begin
                    tx_cnt_d = '0;
                    if (PARITY != 0) begin
                        tx_state_d = TxPar;
                        tx_d       = tx_par_q;
                    end else begin
                        tx_state_d = TxStop;
                        tx_d       = 1'b1;
                    end
                end else begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_d     = tx_sh_q[1];
                    tx_cnt_d = tx_cnt_q + 4'd1;
                end
            end
            TxPar: if (tx_bit_end) begin
                tx_state_d = TxStop;
                tx_d       = 1'b1;
                tx_cnt_d   = '0;
            end
            TxStop: if (tx_bit_end) begin
                if (tx_cnt_q == StopLast) tx_state_d = TxIdle;
                else tx_cnt_d = tx_cnt_q + 4'd1;
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TxIdle;
            tx_div_q   <= '0;
            tx_os_q    <= '0;
            tx_cnt_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_en_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_os_q    <= tx_os_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            tx_en_q    <= 1'b1;
        end
    end

    assign bus.tx              = tx_q;
    assign bus.tx_ready        = tx_ready;
    assign bus.rx_valid        = (rx_state_q == RxDone);
    assign bus.parity_err      = (rx_state_q == RxDone) && rx_par_bad;
    assign bus.frame_err       = (rx_state_q == RxErr);
    assign bus.rx_data         = rx_data_q;
    assign bus.is_receiving    = (rx_state_q != RxIdle);
    assign bus.is_transmitting = (tx_state_q != TxIdle);
    assign bus.cts             = bus.rts & ~bus.busy;
endmodule
